// File: rtl/icache_pkg.sv
// Shared types and constants for the set-associative instruction cache.
// Holds the controller state encoding, CACHE-op codes and AXI3 read-channel constants.
package icache_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StMissAr,
      StMissR,
      StFill,
      StFillErr,
      StResp,
      StUncAr,
      StUncR,
      StUncResp,
      StCop
   } state_e;

   localparam logic [4:0] CopNone   = 5'h00;
   localparam logic [4:0] CopIdxInv = 5'h01;
   localparam logic [4:0] CopHitInv = 5'h02;

   localparam int unsigned AxiIdW    = 4;
   localparam int unsigned AxiLenW   = 4;
   localparam int unsigned AxiSizeW  = 3;
   localparam int unsigned AxiBurstW = 2;
   localparam int unsigned AxiRespW  = 2;

   localparam logic [AxiSizeW-1:0]  ArSizeWord  = 3'b010;
   localparam logic [AxiBurstW-1:0] ArBurstIncr = 2'b01;

endpackage

// File: rtl/icache_way.sv
// One cache way: tag, valid and line storage for every set.
// Asynchronous read, synchronous write; valid bits clear asynchronously on reset.
module icache_way #(
   parameter int unsigned IndexSize   = 6,
   parameter int unsigned WordOffSize = 4,
   parameter int unsigned TagSize     = 20
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [IndexSize-1:0]                 idx_i,
   output logic                                 rd_valid_o,
   output logic [TagSize-1:0]                   rd_tag_o,
   output logic [(1 << WordOffSize)-1:0][31:0]  rd_line_o,
   input  logic                                 wr_en_i,
   input  logic [TagSize-1:0]                   wr_tag_i,
   input  logic [(1 << WordOffSize)-1:0][31:0]  wr_line_i,
   input  logic                                 clr_en_i
);

   localparam int unsigned Sets  = 1 << IndexSize;
   localparam int unsigned Words = 1 << WordOffSize;

   logic [Sets-1:0]        valid_q;
   logic [TagSize-1:0]     tag_q  [Sets];
   logic [Words-1:0][31:0] data_q [Sets];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[idx_i]  <= wr_tag_i;
         data_q[idx_i] <= wr_line_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[idx_i] <= 1'b1;
      end else if (clr_en_i) begin
         valid_q[idx_i] <= 1'b0;
      end
   end

   assign rd_valid_o = valid_q[idx_i];
   assign rd_tag_o   = tag_q[idx_i];
   assign rd_line_o  = data_q[idx_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin replacement, dual-issue fetch,
// uncached bypass and CACHE-op invalidation, refilling over an AXI3 read port.
module icache_assoc
   import icache_pkg::*;
#(
   parameter int unsigned WAYS            = 2,
   parameter int unsigned INDEX_SIZE      = 6,
   parameter int unsigned WORD_OFF_SIZE   = 4,
   parameter int unsigned TAG_SIZE        = 32 - INDEX_SIZE - WORD_OFF_SIZE - 2,
   parameter logic [3:0]  AXI_ID_CACHED   = 4'd3,
   parameter logic [3:0]  AXI_ID_UNCACHED = 4'd2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [31:0]          i_addr,
   input  logic                 i_en,
   input  logic                 cached,
   input  logic [4:0]           c_op,
   output logic                 i_stall,
   output logic                 i_ready_1,
   output logic                 i_ready_2,
   output logic [31:0]          i_rdata_1,
   output logic [31:0]          i_rdata_2,
   output logic [AxiIdW-1:0]    arid,
   output logic [31:0]          araddr,
   output logic [AxiLenW-1:0]   arlen,
   output logic [AxiSizeW-1:0]  arsize,
   output logic [AxiBurstW-1:0] arburst,
   output logic                 arvalid,
   input  logic                 arready,
   input  logic [AxiIdW-1:0]    rid,
   input  logic [31:0]          rdata,
   input  logic [AxiRespW-1:0]  rresp,
   input  logic                 rlast,
   input  logic                 rvalid,
   output logic                 rready
);

   localparam int unsigned Sets   = 1 << INDEX_SIZE;
   localparam int unsigned Words  = 1 << WORD_OFF_SIZE;
   localparam int unsigned PtrW   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned IdxLsb = WORD_OFF_SIZE + 2;
   localparam logic [WORD_OFF_SIZE-1:0] OffMax = '1;

   // Reset asserts asynchronously but is released on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rst_sync_q <= 2'b00;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   state_e                    state_q, state_d;
   logic [31:0]               req_q, req_d;
   logic [4:0]                cop_q, cop_d;
   logic [WORD_OFF_SIZE-1:0]  cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic [31:0]               unc_q, unc_d;
   logic [Words-1:0][31:0]    fill_q, fill_d;
   logic                      arvalid_q, arvalid_d;
   logic [31:0]               araddr_q, araddr_d;
   logic [AxiLenW-1:0]        arlen_q, arlen_d;
   logic [AxiIdW-1:0]         arid_q, arid_d;
   logic [PtrW-1:0]           rr_q [Sets];

   logic [INDEX_SIZE-1:0]     lkp_idx;
   logic [TAG_SIZE-1:0]       lkp_tag;
   logic [WAYS-1:0]           way_valid, hit_vec, way_we, way_clr;
   logic [TAG_SIZE-1:0]       way_tag  [WAYS];
   logic [Words-1:0][31:0]    way_line [WAYS];
   logic [Words-1:0][31:0]    hit_line, resp_line;
   logic [WORD_OFF_SIZE-1:0]  resp_off;
   logic                      resp_en, hit, rr_we, victim_inv;
   logic [PtrW-1:0]           victim, rr_next, cop_way;

   // Lookup uses the live fetch address in IDLE and the captured request otherwise.
   assign lkp_idx = (state_q == StIdle) ? i_addr[IdxLsb +: INDEX_SIZE] : req_q[IdxLsb +: INDEX_SIZE];
   assign lkp_tag = (state_q == StIdle) ? i_addr[31 -: TAG_SIZE] : req_q[31 -: TAG_SIZE];
   assign cop_way = (WAYS > 1) ? req_q[31 -: PtrW] : '0;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way #(
         .IndexSize   (INDEX_SIZE),
         .WordOffSize (WORD_OFF_SIZE),
         .TagSize     (TAG_SIZE)
      ) u_way (
         .clk_i      (clk),
         .rst_ni     (rst_n),
         .idx_i      (lkp_idx),
         .rd_valid_o (way_valid[w]),
         .rd_tag_o   (way_tag[w]),
         .rd_line_o  (way_line[w]),
         .wr_en_i    (way_we[w]),
         .wr_tag_i   (lkp_tag),
         .wr_line_i  (fill_q),
         .clr_en_i   (way_clr[w])
      );
      assign hit_vec[w] = way_valid[w] && (way_tag[w] == lkp_tag);
   end

   assign hit = |hit_vec;

   always_comb begin
      hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_vec[w]) hit_line = hit_line | way_line[w];
      end
   end

   // Lowest invalid way wins; otherwise the set's round-robin pointer picks the victim.
   always_comb begin
      victim     = rr_q[lkp_idx];
      victim_inv = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!way_valid[w]) begin
            victim     = PtrW'(w);
            victim_inv = 1'b1;
         end
      end
      rr_next = (rr_q[lkp_idx] == PtrW'(WAYS - 1)) ? '0 : rr_q[lkp_idx] + 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      cop_d     = cop_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      unc_d     = unc_q;
      fill_d    = fill_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arid_d    = arid_q;
      way_we    = '0;
      way_clr   = '0;
      rr_we     = 1'b0;
      resp_en   = 1'b0;
      resp_line = hit_line;
      resp_off  = i_addr[2 +: WORD_OFF_SIZE];
      i_stall   = 1'b0;
      i_ready_1 = 1'b0;
      i_ready_2 = 1'b0;
      i_rdata_1 = '0;
      i_rdata_2 = '0;

      unique case (state_q)
         StIdle: begin
            if (c_op != CopNone) begin
               req_d   = i_addr;
               cop_d   = c_op;
               state_d = StCop;
            end else if (i_en) begin
               if (cached && hit) begin
                  resp_en = 1'b1;
               end else begin
                  i_stall = 1'b1;
                  req_d   = i_addr;
                  state_d = cached ? StMissAr : StUncAr;
               end
            end
         end
         StMissAr, StUncAr: begin
            i_stall = 1'b1;
            if (!arvalid_q) begin
               if (!i_en) begin
                  state_d = StIdle;
               end else begin
                  arvalid_d = 1'b1;
                  cnt_d     = '0;
                  err_d     = 1'b0;
                  if (state_q == StMissAr) begin
                     araddr_d = {req_q[31:IdxLsb], IdxLsb'(0)};
                     arlen_d  = AxiLenW'(Words - 1);
                     arid_d   = AXI_ID_CACHED;
                  end else begin
                     araddr_d = req_q;
                     arlen_d  = '0;
                     arid_d   = AXI_ID_UNCACHED;
                  end
               end
            end else if (arready) begin
               arvalid_d = 1'b0;
               state_d   = (state_q == StMissAr) ? StMissR : StUncR;
            end
         end
         StMissR: begin
            i_stall = 1'b1;
            if (rvalid && (rid == AXI_ID_CACHED)) begin
               fill_d[cnt_q] = rdata;
               cnt_d         = cnt_q + 1'b1;
               if (rresp != '0) err_d = 1'b1;
               if (rlast) state_d = err_d ? StFillErr : StFill;
            end
         end
         StFill: begin
            i_stall        = 1'b1;
            way_we[victim] = 1'b1;
            rr_we          = !victim_inv;
            state_d        = StResp;
         end
         StResp: begin
            resp_en   = 1'b1;
            resp_line = fill_q;
            resp_off  = req_q[2 +: WORD_OFF_SIZE];
            state_d   = StIdle;
         end
         StFillErr: begin
            state_d = StIdle;
         end
         StUncR: begin
            i_stall = 1'b1;
            if (rvalid && (rid == AXI_ID_UNCACHED)) begin
               unc_d   = rdata;
               state_d = StUncResp;
            end
         end
         StUncResp: begin
            i_ready_1 = 1'b1;
            i_rdata_1 = unc_q;
            state_d   = StIdle;
         end
         StCop: begin
            i_stall = 1'b1;
            if (cop_q == CopIdxInv)      way_clr[cop_way] = 1'b1;
            else if (cop_q == CopHitInv) way_clr          = hit_vec;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // No wrap into the next line for the second slot.
      if (resp_en) begin
         i_ready_1 = 1'b1;
         i_rdata_1 = resp_line[resp_off];
         if (resp_off != OffMax) begin
            i_ready_2 = 1'b1;
            i_rdata_2 = resp_line[resp_off + 1'b1];
         end
      end

      if (!rst_n) begin
         i_stall   = 1'b0;
         i_ready_1 = 1'b0;
         i_ready_2 = 1'b0;
         i_rdata_1 = '0;
         i_rdata_2 = '0;
         way_we    = '0;
         way_clr   = '0;
         rr_we     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         req_q     <= '0;
         cop_q     <= CopNone;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         unc_q     <= '0;
         fill_q    <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arid_q    <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         cop_q     <= cop_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         unc_q     <= unc_d;
         fill_q    <= fill_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arid_q    <= arid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < Sets; s++) rr_q[s] <= '0;
      end else if (rr_we) begin
         rr_q[lkp_idx] <= rr_next;
      end
   end

   assign arvalid = arvalid_q;
   assign araddr  = araddr_q;
   assign arlen   = arlen_q;
   assign arid    = arid_q;
   assign arsize  = ArSizeWord;
   assign arburst = ArBurstIncr;
   assign rready  = 1'b1;

   a_no_multi_hit : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit_vec));

endmodule

// File: tb/tb_icache_assoc.sv
// Directed self-checking bench for icache_assoc (2-way, 64 sets, 16-word lines).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_icache_assoc;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] i_addr;
   logic        i_en, cached;
   logic [4:0]  c_op;
   logic        i_stall, i_ready_1, i_ready_2;
   logic [31:0] i_rdata_1, i_rdata_2;
   logic [3:0]  arid, arlen, rid;
   logic [31:0] araddr, rdata;
   logic [2:0]  arsize;
   logic [1:0]  arburst, rresp;
   logic        arvalid, arready, rlast, rvalid, rready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   icache_assoc dut (
      .clk       (clk),
      .resetn    (resetn),
      .i_addr    (i_addr),
      .i_en      (i_en),
      .cached    (cached),
      .c_op      (c_op),
      .i_stall   (i_stall),
      .i_ready_1 (i_ready_1),
      .i_ready_2 (i_ready_2),
      .i_rdata_1 (i_rdata_1),
      .i_rdata_2 (i_rdata_2),
      .arid      (arid),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .rid       (rid),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, need completion");
      $fatal(1);
   end

   // Waits (bounded) for an AR request, records it and accepts it with one arready pulse.
   task automatic wait_ar(output bit seen, output logic [31:0] a, output logic [3:0] l,
                          output logic [3:0] id);
      seen = 1'b0;
      a = '0; l = '0; id = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (arvalid) begin
            seen = 1'b1;
            a = araddr; l = arlen; id = arid;
            break;
         end
      end
      if (seen) begin
         arready = 1'b1;
         @(negedge clk);
         arready = 1'b0;
      end
   endtask

   task automatic send_beats(input logic [3:0] id, input int n, input logic [31:0] base,
                             input int err_at, input int stray_at);
      for (int k = 0; k < n; k++) begin
         if (k == stray_at) begin
            rvalid = 1'b1; rid = 4'd7; rdata = 32'h0000_0BAD; rlast = 1'b0; rresp = 2'b00;
            @(negedge clk);
         end
         rvalid = 1'b1; rid = id; rdata = base + k; rlast = (k == n - 1);
         rresp = (k == err_at) ? 2'b10 : 2'b00;
         @(negedge clk);
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0;
   endtask

   task automatic wait_unstall(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (!i_stall) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Cached fetch that is expected to miss: serves a full clean burst, returns in RESP.
   task automatic fill_line(input logic [31:0] addr, input logic [31:0] base, output bit ok);
      bit seen, unst;
      logic [31:0] a;
      logic [3:0]  l, id;
      i_addr = addr; i_en = 1'b1; cached = 1'b1;
      wait_ar(seen, a, l, id);
      send_beats(4'd3, 16, base, -1, -1);
      wait_unstall(unst);
      ok = seen && unst;
      i_en = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0; i_addr = '0; i_en = 1'b0; cached = 1'b1; c_op = 5'h00;
      arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({arvalid, i_stall, i_ready_1, i_ready_2} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b, need 0000", {arvalid, i_stall, i_ready_1, i_ready_2});
      end
      checks++;
      if ({araddr, arlen, arid, i_rdata_1, i_rdata_2} !== 104'd0) begin
         errors++;
         $display("FAIL reset_values: araddr=%h arlen=%h arid=%h rd1=%h rd2=%h, need all 0",
                  araddr, arlen, arid, i_rdata_1, i_rdata_2);
      end
      checks++;
      if ({rready, arsize, arburst} !== {1'b1, 3'b010, 2'b01}) begin
         errors++;
         $display("FAIL constants: rready=%b arsize=%b arburst=%b, need 1 010 01",
                  rready, arsize, arburst);
      end
      resetn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_cold_miss;
      bit seen, ok;
      logic [31:0] a;
      logic [3:0]  l, id;
      @(negedge clk);
      i_addr = 32'h1FC0_0004; i_en = 1'b1; cached = 1'b1;
      #1;
      checks++;
      if (i_stall !== 1'b1) begin
         errors++; $display("FAIL cold_stall: got %b, need 1", i_stall);
      end
      wait_ar(seen, a, l, id);
      checks++;
      if ({seen, a, l, id} !== {1'b1, 32'h1FC0_0000, 4'hF, 4'd3}) begin
         errors++;
         $display("FAIL cold_ar: seen=%b araddr=%h arlen=%h arid=%h, need 1 1fc00000 f 3",
                  seen, a, l, id);
      end
      send_beats(4'd3, 16, 32'h100, -1, 3);
      wait_unstall(ok);
      checks++;
      if ({ok, i_ready_1, i_ready_2, i_rdata_1, i_rdata_2} !== {3'b111, 32'h101, 32'h102}) begin
         errors++;
         $display("FAIL cold_resp: ok=%b r1=%b r2=%b d1=%h d2=%h, need 1 1 1 101 102",
                  ok, i_ready_1, i_ready_2, i_rdata_1, i_rdata_2);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({i_stall, i_ready_1, i_rdata_1, i_rdata_2} !== {2'b01, 32'h101, 32'h102}) begin
         errors++;
         $display("FAIL cold_rehit: stall=%b r1=%b d1=%h d2=%h, need 0 1 101 102",
                  i_stall, i_ready_1, i_rdata_1, i_rdata_2);
      end
      i_en = 1'b0;
   endtask

   task automatic test_offset_edge;
      @(negedge clk);
      i_addr = 32'h1FC0_003C; i_en = 1'b1; cached = 1'b1;
      #1;
      checks++;
      if ({i_stall, i_ready_1, i_ready_2, i_rdata_1, i_rdata_2} !==
          {3'b010, 32'h10F, 32'h0}) begin
         errors++;
         $display("FAIL off15: stall=%b r1=%b r2=%b d1=%h d2=%h, need 0 1 0 10f 0",
                  i_stall, i_ready_1, i_ready_2, i_rdata_1, i_rdata_2);
      end
      @(negedge clk);
      i_addr = 32'h1FC0_0038;
      #1;
      checks++;
      if ({i_ready_1, i_ready_2, i_rdata_1, i_rdata_2} !== {2'b11, 32'h10E, 32'h10F}) begin
         errors++;
         $display("FAIL off14: r1=%b r2=%b d1=%h d2=%h, need 1 1 10e 10f",
                  i_ready_1, i_ready_2, i_rdata_1, i_rdata_2);
      end
      i_en = 1'b0;
   endtask

   task automatic test_replacement;
      bit ok1, ok2;
      fill_line(32'h0000_1000, 32'h300, ok1);
      fill_line(32'h0000_2000, 32'h500, ok2);
      checks++;
      if ({ok1, ok2} !== 2'b11) begin
         errors++; $display("FAIL repl_fills: got %b, need 11", {ok1, ok2});
      end
      @(negedge clk);
      i_addr = 32'h0000_1000; i_en = 1'b1; cached = 1'b1;
      #1;
      checks++;
      if ({i_stall, i_rdata_1} !== {1'b0, 32'h300}) begin
         errors++; $display("FAIL repl_second_hit: stall=%b d1=%h, need 0 300", i_stall, i_rdata_1);
      end
      @(negedge clk);
      i_addr = 32'h0000_2004;
      #1;
      checks++;
      if ({i_stall, i_rdata_1} !== {1'b0, 32'h501}) begin
         errors++; $display("FAIL repl_third_hit: stall=%b d1=%h, need 0 501", i_stall, i_rdata_1);
      end
      @(negedge clk);
      i_addr = 32'h1FC0_0000;
      #1;
      checks++;
      if (i_stall !== 1'b1) begin
         errors++; $display("FAIL repl_first_evicted: stall=%b, need 1", i_stall);
      end
      fill_line(32'h1FC0_0000, 32'h100, ok1);
      @(negedge clk);
      i_addr = 32'h0000_1000; i_en = 1'b1;
      #1;
      checks++;
      if ({ok1, i_stall} !== 2'b11) begin
         errors++; $display("FAIL repl_rr_advance: ok=%b stall=%b, need 1 1", ok1, i_stall);
      end
      fill_line(32'h0000_1000, 32'h300, ok1);
      @(negedge clk);
      i_addr = 32'h1FC0_0008; i_en = 1'b1;
      #1;
      checks++;
      if ({ok1, i_stall, i_rdata_1} !== {2'b10, 32'h102}) begin
         errors++;
         $display("FAIL repl_survivor: ok=%b stall=%b d1=%h, need 1 0 102", ok1, i_stall, i_rdata_1);
      end
      i_en = 1'b0;
   endtask

   task automatic test_uncached;
      bit seen, ok;
      logic [31:0] a;
      logic [3:0]  l, id;
      @(negedge clk);
      i_addr = 32'hBFC0_0000; i_en = 1'b1; cached = 1'b0;
      wait_ar(seen, a, l, id);
      checks++;
      if ({seen, a, l, id} !== {1'b1, 32'hBFC0_0000, 4'h0, 4'd2}) begin
         errors++;
         $display("FAIL unc_ar: seen=%b araddr=%h arlen=%h arid=%h, need 1 bfc00000 0 2",
                  seen, a, l, id);
      end
      send_beats(4'd2, 1, 32'hDEAD_BEEF, -1, -1);
      wait_unstall(ok);
      checks++;
      if ({ok, i_ready_1, i_ready_2, i_rdata_1} !== {3'b110, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL unc_resp: ok=%b r1=%b r2=%b d1=%h, need 1 1 0 deadbeef",
                  ok, i_ready_1, i_ready_2, i_rdata_1);
      end
      wait_ar(seen, a, l, id);
      checks++;
      if ({seen, a, id} !== {1'b1, 32'hBFC0_0000, 4'd2}) begin
         errors++;
         $display("FAIL unc_refetch_ar: seen=%b araddr=%h arid=%h, need 1 bfc00000 2", seen, a, id);
      end
      send_beats(4'd2, 1, 32'h1234_5678, -1, -1);
      wait_unstall(ok);
      checks++;
      if ({ok, i_ready_1, i_rdata_1} !== {2'b11, 32'h1234_5678}) begin
         errors++;
         $display("FAIL unc_refetch_resp: ok=%b r1=%b d1=%h, need 1 1 12345678",
                  ok, i_ready_1, i_rdata_1);
      end
      i_en = 1'b0; cached = 1'b1;
   endtask

   task automatic test_cache_ops;
      bit ok;
      int stalls, ars;
      @(negedge clk);
      i_addr = 32'h1FC0_0000; i_en = 1'b1; cached = 1'b1;
      #1;
      checks++;
      if ({i_stall, i_rdata_1} !== {1'b0, 32'h100}) begin
         errors++; $display("FAIL cop_pre_hit: stall=%b d1=%h, need 0 100", i_stall, i_rdata_1);
      end
      @(negedge clk);
      i_en = 1'b0; c_op = 5'h02;
      @(negedge clk);
      c_op = 5'h00;
      #1;
      checks++;
      if (i_stall !== 1'b1) begin
         errors++; $display("FAIL cop_stall: stall=%b, need 1", i_stall);
      end
      @(negedge clk);
      i_addr = 32'h0000_1000; i_en = 1'b1;
      #1;
      checks++;
      if ({i_stall, i_rdata_1} !== {1'b0, 32'h300}) begin
         errors++; $display("FAIL hitinv_other_way: stall=%b d1=%h, need 0 300", i_stall, i_rdata_1);
      end
      @(negedge clk);
      i_addr = 32'h1FC0_0000;
      #1;
      checks++;
      if (i_stall !== 1'b1) begin
         errors++; $display("FAIL hitinv_miss: stall=%b, need 1", i_stall);
      end
      fill_line(32'h1FC0_0000, 32'h100, ok);
      stalls = 0; ars = 0;
      @(negedge clk);
      i_addr = 32'h0000_0140; c_op = 5'h01;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(negedge clk);
            c_op = 5'h00;
         end
         #1;
         if (i_stall) stalls++;
         if (arvalid) ars++;
      end
      checks++;
      if ({stalls, ars} !== {32'd1, 32'd0}) begin
         errors++; $display("FAIL idxinv_empty: stalls=%0d ars=%0d, need 1 0", stalls, ars);
      end
      @(negedge clk);
      i_addr = 32'h0000_0000; c_op = 5'h01;
      @(negedge clk);
      c_op = 5'h00;
      @(negedge clk);
      i_addr = 32'h1FC0_0000; i_en = 1'b1;
      #1;
      checks++;
      if ({ok, i_stall, i_rdata_1} !== {2'b10, 32'h100}) begin
         errors++;
         $display("FAIL idxinv_way1_kept: ok=%b stall=%b d1=%h, need 1 0 100", ok, i_stall, i_rdata_1);
      end
      @(negedge clk);
      i_addr = 32'h0000_1000;
      #1;
      checks++;
      if (i_stall !== 1'b1) begin
         errors++; $display("FAIL idxinv_way0_cleared: stall=%b, need 1", i_stall);
      end
      fill_line(32'h0000_1000, 32'h300, ok);
   endtask

   task automatic test_fill_error;
      bit seen, ok;
      logic [31:0] a;
      logic [3:0]  l, id;
      @(negedge clk);
      i_addr = 32'h0000_50C0; i_en = 1'b1; cached = 1'b1;
      wait_ar(seen, a, l, id);
      send_beats(4'd3, 16, 32'h700, 4, -1);
      wait_unstall(ok);
      checks++;
      if ({seen, ok, i_ready_1, i_ready_2} !== 4'b1100) begin
         errors++;
         $display("FAIL err_resp: seen=%b ok=%b r1=%b r2=%b, need 1 1 0 0",
                  seen, ok, i_ready_1, i_ready_2);
      end
      @(negedge clk);
      #1;
      checks++;
      if (i_stall !== 1'b1) begin
         errors++; $display("FAIL err_not_installed: stall=%b, need 1", i_stall);
      end
      fill_line(32'h0000_50C0, 32'h700, ok);
      checks++;
      if ({ok, i_ready_1, i_rdata_1} !== {2'b11, 32'h700}) begin
         errors++;
         $display("FAIL err_retry: ok=%b r1=%b d1=%h, need 1 1 700", ok, i_ready_1, i_rdata_1);
      end
   endtask

   task automatic test_reset_mid_burst;
      bit seen, ok;
      int ars;
      logic [31:0] a;
      logic [3:0]  l, id;
      @(negedge clk);
      i_addr = 32'h0000_4088; i_en = 1'b1; cached = 1'b1;
      wait_ar(seen, a, l, id);
      for (int k = 0; k < 5; k++) begin
         rvalid = 1'b1; rid = 4'd3; rdata = 32'h200 + k; rlast = 1'b0; rresp = 2'b00;
         @(negedge clk);
      end
      rdata = 32'h205;
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if ({arvalid, i_stall, i_ready_1, i_ready_2, i_rdata_1, i_rdata_2} !== 68'd0) begin
         errors++;
         $display("FAIL midburst_reset: arv=%b stall=%b r1=%b r2=%b d1=%h d2=%h, need all 0",
                  arvalid, i_stall, i_ready_1, i_ready_2, i_rdata_1, i_rdata_2);
      end
      rvalid = 1'b0; i_en = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      i_en = 1'b1;
      wait_ar(seen, a, l, id);
      checks++;
      if ({seen, a, l, id} !== {1'b1, 32'h0000_4080, 4'hF, 4'd3}) begin
         errors++;
         $display("FAIL midburst_refetch_ar: seen=%b araddr=%h arlen=%h arid=%h, need 1 4080 f 3",
                  seen, a, l, id);
      end
      send_beats(4'd3, 16, 32'h200, -1, -1);
      wait_unstall(ok);
      checks++;
      if ({ok, i_ready_1, i_rdata_1, i_rdata_2} !== {2'b11, 32'h202, 32'h203}) begin
         errors++;
         $display("FAIL midburst_refetch_resp: ok=%b r1=%b d1=%h d2=%h, need 1 1 202 203",
                  ok, i_ready_1, i_rdata_1, i_rdata_2);
      end
      // Previously resident line is gone after reset; withdraw before the AR goes out.
      @(negedge clk);
      i_addr = 32'h1FC0_0000; i_en = 1'b1;
      #1;
      checks++;
      if (i_stall !== 1'b1) begin
         errors++; $display("FAIL reset_cleared_valid: stall=%b, need 1", i_stall);
      end
      @(negedge clk);
      i_en = 1'b0;
      ars = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (arvalid) ars++;
         @(negedge clk);
      end
      #1;
      checks++;
      if ({ars, i_stall} !== {32'd0, 1'b0}) begin
         errors++; $display("FAIL withdraw: ars=%0d stall=%b, need 0 0", ars, i_stall);
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_offset_edge();
      test_replacement();
      test_uncached();
      test_cache_ops();
      test_fill_error();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
